addr_key_unlock: RTL and testbench

- Parametrised address-sequence unlock detector; successor to the fixed 4-step bus-write key PLD.
- Watches qualified write strobes on the board bus and compares an address field against a programmed key sequence.
- Asserts a registered unlock enable when the full sequence matches. Adds a configurable key length and width, an inactivity timeout, explicit relock, and a brute-force lockout.
- Sits between the bus select decode and the gated read-enable drivers.

---
 rtl/addr_key_unlock.sv | 176 +++++++++++++++++
 tb/tb_addr_key_unlock.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/addr_key_unlock.sv
// Purpose: opens a registered unlock enable after a programmed sequence of written address-field values.
// Latency: one cycle from the qualifying write strobe to the stage, unlocked and pulse outputs.
// Backpressure: none; each qualified write is consumed in its own cycle and is ignored during lockout.
module addr_key_unlock #(
    parameter int                          FIELD_W     = 4,
    parameter int                          KEY_LEN     = 4,
    parameter logic [KEY_LEN*FIELD_W-1:0]  KEY         = 16'h28A9,
    parameter logic [FIELD_W-1:0]          RELOCK      = 4'hF,
    parameter int                          TIMEOUT     = 255,
    parameter int                          FAIL_MAX    = 3,
    parameter int                          LOCKOUT_CYC = 4095
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           sel,
    input  logic                           wr,
    input  logic [FIELD_W-1:0]             field,
    output logic                           unlocked,
    output logic [$clog2(KEY_LEN+1)-1:0]   stage,
    output logic                           unlock_p,
    output logic                           fail_p,
    output logic                           lockout
);

    localparam int SW = $clog2(KEY_LEN + 1);
    localparam int IW = $clog2(TIMEOUT + 1);
    localparam int LW = $clog2(LOCKOUT_CYC + 1);

    localparam logic [SW-1:0] STAGE_LAST = SW'(KEY_LEN - 1);
    localparam logic [SW-1:0] STAGE_FULL = SW'(KEY_LEN);
    localparam logic [IW-1:0] IDLE_LAST  = IW'(TIMEOUT - 1);
    localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCKOUT_CYC - 1);
    localparam logic [3:0]    FAIL_LAST  = 4'(FAIL_MAX - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MATCH,
        S_UNLOCKED,
        S_LOCKOUT
    } state_t;

    state_t            state_q;
    logic [SW-1:0]     stage_q;
    logic [IW-1:0]     idle_q;
    logic [LW-1:0]     lock_q;
    logic [3:0]        fail_q;
    logic              strobe_q;
    logic              unlocked_q;
    logic              unlock_p_q;
    logic              fail_p_q;
    logic              lockout_q;

    // Key table indexed by stage; sized to the full stage range so any stage value is a legal index.
    logic [FIELD_W-1:0] key_tab [2**SW];

    for (genvar g = 0; g < 2**SW; g++) begin : g_key
        if (g < KEY_LEN) begin : g_used
            assign key_tab[g] = KEY[(KEY_LEN-1-g)*FIELD_W +: FIELD_W];
        end else begin : g_unused
            assign key_tab[g] = '0;
        end
    end

    logic strobe;
    logic qa;
    logic hit;
    logic hit0;
    logic mismatch;
    logic timeout;
    logic fail_ev;
    logic lock_ev;

    // Rising-edge strobe qualification, key compare for the current step, and abort conditions.
    always_comb begin
        strobe   = sel & wr;
        qa       = strobe & ~strobe_q;
        hit      = (field == key_tab[stage_q]);
        hit0     = (field == key_tab[0]);
        mismatch = (state_q == S_MATCH) && qa && !hit;
        timeout  = (state_q == S_MATCH) && !qa && (idle_q == IDLE_LAST);
        fail_ev  = mismatch | timeout;
        lock_ev  = fail_ev && (fail_q >= FAIL_LAST);
    end

    // Sequence FSM with counters and registered outputs; aborts take precedence over step handling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            stage_q    <= '0;
            idle_q     <= '0;
            lock_q     <= '0;
            fail_q     <= '0;
            strobe_q   <= 1'b0;
            unlocked_q <= 1'b0;
            unlock_p_q <= 1'b0;
            fail_p_q   <= 1'b0;
            lockout_q  <= 1'b0;
        end else begin
            strobe_q   <= strobe;
            unlock_p_q <= 1'b0;
            fail_p_q   <= 1'b0;
            if (fail_ev) begin
                fail_p_q <= 1'b1;
                idle_q   <= '0;
                if (fail_q != 4'hF) begin
                    fail_q <= fail_q + 4'd1;
                end
                if (lock_ev) begin
                    // Lockout wins over restarting at step 1.
                    state_q   <= S_LOCKOUT;
                    stage_q   <= '0;
                    lockout_q <= 1'b1;
                    lock_q    <= '0;
                end else if (mismatch && hit0) begin
                    state_q <= S_MATCH;
                    stage_q <= SW'(1);
                end else begin
                    state_q <= S_IDLE;
                    stage_q <= '0;
                end
            end else begin
                case (state_q)
                    S_IDLE, S_MATCH: begin
                        if (qa && hit) begin
                            idle_q <= '0;
                            if (stage_q == STAGE_LAST) begin
                                state_q    <= S_UNLOCKED;
                                stage_q    <= STAGE_FULL;
                                unlocked_q <= 1'b1;
                                unlock_p_q <= 1'b1;
                                fail_q     <= '0;
                            end else begin
                                state_q <= S_MATCH;
                                stage_q <= stage_q + SW'(1);
                            end
                        end else if (state_q == S_IDLE) begin
                            idle_q <= '0;
                        end else if (idle_q != IDLE_LAST) begin
                            idle_q <= idle_q + IW'(1);
                        end
                    end
                    S_UNLOCKED: begin
                        if (qa && field == RELOCK) begin
                            state_q    <= S_IDLE;
                            stage_q    <= '0;
                            unlocked_q <= 1'b0;
                            idle_q     <= '0;
                        end
                    end
                    S_LOCKOUT: begin
                        if (lock_q == LOCK_LAST) begin
                            state_q   <= S_IDLE;
                            lockout_q <= 1'b0;
                            fail_q    <= '0;
                            lock_q    <= '0;
                            idle_q    <= '0;
                        end else begin
                            lock_q <= lock_q + LW'(1);
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        stage_q <= '0;
                    end
                endcase
            end
        end
    end

    assign unlocked = unlocked_q;
    assign stage    = stage_q;
    assign unlock_p = unlock_p_q;
    assign fail_p   = fail_p_q;
    assign lockout  = lockout_q;

endmodule

// File: tb/tb_addr_key_unlock.sv
// Bench for addr_key_unlock: a 4-step default instance and a 2-step (5,C) instance share one input bus.
// Each cycle the reference model predicts both instances' outputs and queues them; a negedge monitor compares.
// Directed scenarios cover the key, restart, timeout, lockout, held strobe, relock and async reset, then random traffic.
module tb_addr_key_unlock;

    localparam int TMO  = 255;
    localparam int FMAX = 3;
    localparam int LCYC = 4095;
    localparam int RLK  = 15;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sel;
    logic       wr;
    logic [3:0] field;

    logic       unlocked1, unlock_p1, fail_p1, lockout1;
    logic [2:0] stage1;
    logic       unlocked2, unlock_p2, fail_p2, lockout2;
    logic [1:0] stage2;

    addr_key_unlock dut (
        .clk(clk), .rst_n(rst_n), .sel(sel), .wr(wr), .field(field),
        .unlocked(unlocked1), .stage(stage1), .unlock_p(unlock_p1),
        .fail_p(fail_p1), .lockout(lockout1)
    );

    addr_key_unlock #(.KEY_LEN(2), .KEY(8'h5C)) dut2 (
        .clk(clk), .rst_n(rst_n), .sel(sel), .wr(wr), .field(field),
        .unlocked(unlocked2), .stage(stage2), .unlock_p(unlock_p2),
        .fail_p(fail_p2), .lockout(lockout2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       unl;
        logic [3:0] stage;
        logic       up;
        logic       fp;
        logic       lo;
    } obs_t;

    obs_t q0[$];
    obs_t q1[$];

    int n_pass  = 0;
    int n_total = 0;
    int cyc_n   = 0;

    // Reference model state, one slot per instance.
    int key_a [2][8];
    int klen  [2];
    int prog  [2];
    int fails [2];
    int idle  [2];
    int lockl [2];
    bit unl   [2];
    bit prev  [2];

    task automatic check(input string nm, input obs_t a, input obs_t e);
        n_total++;
        if (a === e) begin
            n_pass++;
        end else begin
            $display("FAIL %s t=%0t got unl=%b stage=%0d up=%b fp=%b lo=%b want unl=%b stage=%0d up=%b fp=%b lo=%b",
                     nm, $time, a.unl, a.stage, a.up, a.fp, a.lo, e.unl, e.stage, e.up, e.fp, e.lo);
        end
    endtask

    task automatic do_fail(input int m, input bit restart);
        idle[m] = 0;
        fails[m]++;
        if (fails[m] >= FMAX) begin
            lockl[m] = LCYC;
            prog[m]  = 0;
        end else begin
            prog[m] = restart ? 1 : 0;
        end
    endtask

    // Predicts the outputs visible after the coming clock edge from the inputs currently driven.
    task automatic model_step(input int m, output obs_t o);
        bit s, qa, up, fp;
        up = 0;
        fp = 0;
        if (!rst_n) begin
            prog[m] = 0; fails[m] = 0; idle[m] = 0; lockl[m] = 0; unl[m] = 0; prev[m] = 0;
        end else begin
            s  = sel & wr;
            qa = s && !prev[m];
            prev[m] = s;
            if (lockl[m] > 0) begin
                lockl[m]--;
                if (lockl[m] == 0) fails[m] = 0;
            end else if (unl[m]) begin
                if (qa && int'(field) == RLK) begin
                    unl[m]  = 0;
                    prog[m] = 0;
                end
            end else if (qa && int'(field) == key_a[m][prog[m]]) begin
                prog[m]++;
                idle[m] = 0;
                if (prog[m] == klen[m]) begin
                    unl[m] = 1; up = 1; fails[m] = 0;
                end
            end else if (prog[m] == 0) begin
                idle[m] = 0;
            end else if (qa) begin
                fp = 1;
                do_fail(m, int'(field) == key_a[m][0]);
            end else begin
                idle[m]++;
                if (idle[m] >= TMO) begin
                    fp = 1;
                    do_fail(m, 1'b0);
                end
            end
        end
        o.unl   = unl[m];
        o.stage = 4'(prog[m]);
        o.up    = up;
        o.fp    = fp;
        o.lo    = (lockl[m] > 0);
    endtask

    task automatic cyc(input logic s, input logic w, input logic [3:0] f);
        obs_t e0, e1;
        sel   = s;
        wr    = w;
        field = f;
        model_step(0, e0);
        model_step(1, e1);
        @(posedge clk);
        q0.push_back(e0);
        q1.push_back(e1);
        cyc_n++;
        #1;
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'($urandom_range(0, 15)));
    endtask

    task automatic pulse(input logic [3:0] f, input int gap);
        cyc(1'b1, 1'b1, f);
        idle_n(gap);
    endtask

    task automatic key4();
        pulse(4'h2, 3); pulse(4'h8, 3); pulse(4'hA, 3); pulse(4'h9, 3);
    endtask

    // Monitor: compares each DUT against its queued prediction away from the active edge.
    always @(negedge clk) begin
        obs_t e, a;
        if (q0.size() != 0) begin
            e = q0.pop_front();
            a = {unlocked1, {1'b0, stage1}, unlock_p1, fail_p1, lockout1};
            check("k4_outputs", a, e);
        end
        if (q1.size() != 0) begin
            e = q1.pop_front();
            a = {unlocked2, {2'b00, stage2}, unlock_p2, fail_p2, lockout2};
            check("k2_outputs", a, e);
        end
    end

    initial begin
        int   r;
        int   stop_at;
        logic [3:0] f;
        key_a[0][0] = 2; key_a[0][1] = 8; key_a[0][2] = 10; key_a[0][3] = 9; klen[0] = 4;
        key_a[1][0] = 5; key_a[1][1] = 12; klen[1] = 2;
        for (int i = 4; i < 8; i++) key_a[0][i] = 0;
        for (int i = 2; i < 8; i++) key_a[1][i] = 0;
        rst_n = 1'b0; sel = 1'b0; wr = 1'b0; field = '0;

        idle_n(3);
        rst_n = 1'b1;
        idle_n(2);

        // Plain key then relock.
        key4();
        pulse(4'hF, 3);

        // Mismatch on a key[0] value restarts at step 1.
        pulse(4'h2, 3); pulse(4'h8, 3); key4();
        pulse(4'hF, 3);

        // Timeout fires on idle cycle 255; a qa on that cycle is processed instead.
        pulse(4'h2, 0); idle_n(256);
        pulse(4'h2, 0); idle_n(254); pulse(4'h8, 3);
        pulse(4'hA, 3); pulse(4'h9, 3); pulse(4'hF, 3);

        // Three failed attempts lock out; key is ignored until lockout expires.
        for (int i = 0; i < 3; i++) begin
            pulse(4'h2, 2); pulse(4'h3, 2);
        end
        key4();
        idle_n(4100);
        key4();
        pulse(4'hF, 3);

        // Held strobe counts once; relock then a fresh first step.
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 4'h2);
        idle_n(3);
        pulse(4'h8, 3); pulse(4'hA, 3); pulse(4'h9, 3);
        pulse(4'hF, 3);
        pulse(4'h2, 3); pulse(4'h8, 3); pulse(4'hA, 3);

        // Asynchronous reset at stage 3 clears outputs with no clock edge.
        #5;
        rst_n = 1'b0;
        #1;
        check("async_rst_k4", {unlocked1, {1'b0, stage1}, unlock_p1, fail_p1, lockout1}, '0);
        check("async_rst_k2", {unlocked2, {2'b00, stage2}, unlock_p2, fail_p2, lockout2}, '0);
        idle_n(2);
        rst_n = 1'b1;
        idle_n(2);

        // Two-step instance key 5,C.
        pulse(4'h5, 3); pulse(4'hC, 3); pulse(4'hF, 3);

        // Randomized traffic biased toward the key so every state is visited.
        stop_at = cyc_n + 20000;
        while (cyc_n < stop_at) begin
            r = $urandom_range(0, 15);
            if (unl[0]) f = (r < 4) ? 4'hF : 4'($urandom_range(0, 15));
            else if (r < 13) f = 4'(key_a[0][prog[0]]);
            else f = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) f = (r[0]) ? 4'h5 : 4'hC;
            if ($urandom_range(0, 9) == 0) cyc(1'b1, 1'b0, f);
            pulse(f, $urandom_range(0, 5));
            if ($urandom_range(0, 150) == 0) idle_n(260);
        end

        repeat (2) @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
